// File: rtl/temp_entry_pkg.sv
// Shared types and constants for the push-button temperature entry block.
// Provides the FSM state encoding, the edit-digit codes, default parameters,
// the committed-value payload struct and a wrapping BCD digit step helper.
package temp_entry_pkg;

   localparam int unsigned TEMP_W                  = 6;
   localparam int unsigned DIGIT_W                 = 4;
   localparam int unsigned SEL_W                   = 2;
   localparam int unsigned BIN_W                   = 7;
   localparam int unsigned TEMP_MAX_DEFAULT        = 63;
   localparam int unsigned DEBOUNCE_CYCLES_DEFAULT = 500000;

   typedef enum logic [2:0] {
      ENTRY_IDLE      = 3'd0,
      ENTRY_EDIT_SIGN = 3'd1,
      ENTRY_EDIT_TENS = 3'd2,
      ENTRY_EDIT_ONES = 3'd3,
      ENTRY_EDIT_FRAC = 3'd4,
      ENTRY_CONVERT   = 3'd5
   } entry_state_e;

   localparam logic [SEL_W-1:0] EDIT_DIGIT_FRAC = 2'd0;
   localparam logic [SEL_W-1:0] EDIT_DIGIT_ONES = 2'd1;
   localparam logic [SEL_W-1:0] EDIT_DIGIT_TENS = 2'd2;
   localparam logic [SEL_W-1:0] EDIT_DIGIT_SIGN = 2'd3;

   // Committed temperature as handed to the monitor
   typedef struct packed {
      logic               sign;
      logic [TEMP_W-1:0]  temp;
      logic [DIGIT_W-1:0] frac;
   } temp_val_t;

   // Step a digit up or down over 0..max with wrap-around
   function automatic logic [DIGIT_W-1:0] digit_step(
      input logic [DIGIT_W-1:0] d,
      input logic [DIGIT_W-1:0] max,
      input logic               up
   );
      if (up) return (d >= max) ? '0 : d + DIGIT_W'(1);
      else    return (d == '0)  ? max : d - DIGIT_W'(1);
   endfunction

endpackage

// File: rtl/temp_entry_if.sv
// Key and result bundle of temp_entry.
// master: drives the raw active-low keys, receives committed value and staging view.
// slave : the entry block itself.
interface temp_entry_if;
   import temp_entry_pkg::*;

   logic                key_sel_n;
   logic                key_inc_n;
   logic                key_dec_n;
   logic                key_commit_n;
   logic [TEMP_W-1:0]   temp;
   logic [DIGIT_W-1:0]  temp_frac;
   logic                temp_sign;
   logic                temp_valid;
   logic                clamped;
   logic                edit_active;
   logic [SEL_W-1:0]    edit_digit;
   logic [DIGIT_W-1:0]  stg_tens;
   logic [DIGIT_W-1:0]  stg_ones;
   logic [DIGIT_W-1:0]  stg_frac;
   logic                stg_sign;

   modport master (
      output key_sel_n, key_inc_n, key_dec_n, key_commit_n,
      input  temp, temp_frac, temp_sign, temp_valid, clamped,
             edit_active, edit_digit, stg_tens, stg_ones, stg_frac, stg_sign
   );

   modport slave (
      input  key_sel_n, key_inc_n, key_dec_n, key_commit_n,
      output temp, temp_frac, temp_sign, temp_valid, clamped,
             edit_active, edit_digit, stg_tens, stg_ones, stg_frac, stg_sign
   );

endinterface

// File: rtl/temp_entry_key_debounce.sv
// Raw push-button conditioner: 2-FF synchroniser, stability counter, press edge.
// Ports: clk, rst_n (async active-low), key_n (raw active-low button),
//        press (1-cycle pulse per accepted high->low transition, registered).
module temp_entry_key_debounce #(
   parameter int unsigned DEBOUNCE_CYCLES = 4
) (
   input  logic clk,
   input  logic rst_n,
   input  logic key_n,
   output logic press
);

   localparam int unsigned      CNT_W    = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

   logic [1:0]       r_sync;
   logic             r_level;
   logic [CNT_W-1:0] r_cnt;
   logic             r_press;
   logic             w_synced;

   assign w_synced = r_sync[1];
   assign press    = r_press;

   // Counter runs only while the synced level differs from the accepted one;
   // any return to the accepted level reloads it, so only a full stable run is taken.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_sync  <= 2'b11;
         r_level <= 1'b1;
         r_cnt   <= '0;
         r_press <= 1'b0;
      end else begin
         r_sync  <= {r_sync[0], key_n};
         r_press <= 1'b0;
         if (w_synced == r_level) begin
            r_cnt <= '0;
         end else if (r_cnt == CNT_LAST) begin
            r_level <= w_synced;
            r_cnt   <= '0;
            r_press <= ~w_synced;
         end else begin
            r_cnt <= r_cnt + CNT_W'(1);
         end
      end
   end

endmodule

// File: rtl/temp_entry.sv
// Push-button temperature editor: debounced keys drive a digit-by-digit BCD
// editor whose staging digits are decoded to sign / binary integer / tenths on commit.
// Ports: clk, rst_n (async active-low), bus (temp_entry_if.slave: raw keys in,
//        committed value, valid/clamped pulses, edit status and staging digits out).
module temp_entry
   import temp_entry_pkg::*;
#(
   parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT,
   parameter int unsigned TEMP_MAX        = TEMP_MAX_DEFAULT
) (
   input  logic         clk,
   input  logic         rst_n,
   temp_entry_if.slave  bus
);

   localparam logic [DIGIT_W-1:0] DIGIT_MAX  = DIGIT_W'(9);
   localparam logic [DIGIT_W-1:0] TENS_MAX   = DIGIT_W'(TEMP_MAX / 10);
   localparam logic [DIGIT_W-1:0] CLAMP_ONES = DIGIT_W'(TEMP_MAX % 10);
   localparam logic [BIN_W-1:0]   BIN_MAX    = BIN_W'(TEMP_MAX);

   logic w_sel, w_inc, w_dec, w_commit;

   entry_state_e       r_state, w_state_nxt;
   logic [DIGIT_W-1:0] r_stg_tens, r_stg_ones, r_stg_frac;
   logic [DIGIT_W-1:0] w_stg_tens, w_stg_ones, w_stg_frac;
   logic               r_stg_sign, w_stg_sign;
   temp_val_t          r_commit, w_commit_nxt;
   logic               r_valid, w_valid_nxt;
   logic               r_clamped, w_clamped_nxt;
   logic               r_edit_active, w_edit_active_nxt;
   logic [SEL_W-1:0]   r_edit_digit, w_edit_digit_nxt;
   logic [BIN_W-1:0]   w_bin;
   logic               w_step, w_up;

   temp_entry_key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_sel (
      .clk(clk), .rst_n(rst_n), .key_n(bus.key_sel_n), .press(w_sel));
   temp_entry_key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_inc (
      .clk(clk), .rst_n(rst_n), .key_n(bus.key_inc_n), .press(w_inc));
   temp_entry_key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_dec (
      .clk(clk), .rst_n(rst_n), .key_n(bus.key_dec_n), .press(w_dec));
   temp_entry_key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_commit (
      .clk(clk), .rst_n(rst_n), .key_n(bus.key_commit_n), .press(w_commit));

   // tens*10 + ones as shift-and-add, wide enough for 99
   assign w_bin = {r_stg_tens, 3'b000} + {2'b00, r_stg_tens, 1'b0} + {3'b000, r_stg_ones};

   // Digit edit request after priority (commit > sel > inc > dec); inc wins over dec
   assign w_step = ~w_commit & ~w_sel & (w_inc | w_dec);
   assign w_up   = w_inc;

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_state <= ENTRY_IDLE;
      else        r_state <= w_state_nxt;
   end

   // Next state, digit edits and conversion
   always_comb begin
      w_state_nxt       = r_state;
      w_stg_tens        = r_stg_tens;
      w_stg_ones        = r_stg_ones;
      w_stg_frac        = r_stg_frac;
      w_stg_sign        = r_stg_sign;
      w_commit_nxt      = r_commit;
      w_valid_nxt       = 1'b0;
      w_clamped_nxt     = 1'b0;
      w_edit_active_nxt = 1'b0;
      w_edit_digit_nxt  = EDIT_DIGIT_FRAC;

      case (r_state)
         ENTRY_IDLE: begin
            if (!w_commit && w_sel) w_state_nxt = ENTRY_EDIT_SIGN;
         end
         ENTRY_EDIT_SIGN: begin
            if (w_commit)    w_state_nxt = ENTRY_CONVERT;
            else if (w_sel)  w_state_nxt = ENTRY_EDIT_TENS;
            else if (w_step) w_stg_sign  = ~r_stg_sign;
         end
         ENTRY_EDIT_TENS: begin
            if (w_commit)    w_state_nxt = ENTRY_CONVERT;
            else if (w_sel)  w_state_nxt = ENTRY_EDIT_ONES;
            else if (w_step) w_stg_tens  = digit_step(r_stg_tens, TENS_MAX, w_up);
         end
         ENTRY_EDIT_ONES: begin
            if (w_commit)    w_state_nxt = ENTRY_CONVERT;
            else if (w_sel)  w_state_nxt = ENTRY_EDIT_FRAC;
            else if (w_step) w_stg_ones  = digit_step(r_stg_ones, DIGIT_MAX, w_up);
         end
         ENTRY_EDIT_FRAC: begin
            if (w_commit)    w_state_nxt = ENTRY_CONVERT;
            else if (w_sel)  w_state_nxt = ENTRY_EDIT_SIGN;
            else if (w_step) w_stg_frac  = digit_step(r_stg_frac, DIGIT_MAX, w_up);
         end
         ENTRY_CONVERT: begin
            w_state_nxt = ENTRY_IDLE;
            w_valid_nxt = 1'b1;
            if (w_bin > BIN_MAX) begin
               // Saturate and write the saturated digits back so the display agrees
               w_commit_nxt.temp = TEMP_W'(TEMP_MAX);
               w_commit_nxt.frac = DIGIT_MAX;
               w_commit_nxt.sign = r_stg_sign;
               w_clamped_nxt     = 1'b1;
               w_stg_tens        = TENS_MAX;
               w_stg_ones        = CLAMP_ONES;
               w_stg_frac        = DIGIT_MAX;
            end else begin
               w_commit_nxt.temp = TEMP_W'(w_bin);
               w_commit_nxt.frac = r_stg_frac;
               // -0.0 is reported as +0.0
               w_commit_nxt.sign = r_stg_sign & ((w_bin != '0) | (r_stg_frac != '0));
            end
         end
         default: w_state_nxt = ENTRY_IDLE;
      endcase

      case (w_state_nxt)
         ENTRY_EDIT_SIGN: begin w_edit_active_nxt = 1'b1; w_edit_digit_nxt = EDIT_DIGIT_SIGN; end
         ENTRY_EDIT_TENS: begin w_edit_active_nxt = 1'b1; w_edit_digit_nxt = EDIT_DIGIT_TENS; end
         ENTRY_EDIT_ONES: begin w_edit_active_nxt = 1'b1; w_edit_digit_nxt = EDIT_DIGIT_ONES; end
         ENTRY_EDIT_FRAC: begin w_edit_active_nxt = 1'b1; w_edit_digit_nxt = EDIT_DIGIT_FRAC; end
         default:         ;
      endcase
   end

   // Staging digits and registered outputs
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_stg_tens    <= '0;
         r_stg_ones    <= '0;
         r_stg_frac    <= '0;
         r_stg_sign    <= 1'b0;
         r_commit      <= '0;
         r_valid       <= 1'b0;
         r_clamped     <= 1'b0;
         r_edit_active <= 1'b0;
         r_edit_digit  <= EDIT_DIGIT_FRAC;
      end else begin
         r_stg_tens    <= w_stg_tens;
         r_stg_ones    <= w_stg_ones;
         r_stg_frac    <= w_stg_frac;
         r_stg_sign    <= w_stg_sign;
         r_commit      <= w_commit_nxt;
         r_valid       <= w_valid_nxt;
         r_clamped     <= w_clamped_nxt;
         r_edit_active <= w_edit_active_nxt;
         r_edit_digit  <= w_edit_digit_nxt;
      end
   end

   assign bus.temp        = r_commit.temp;
   assign bus.temp_frac   = r_commit.frac;
   assign bus.temp_sign   = r_commit.sign;
   assign bus.temp_valid  = r_valid;
   assign bus.clamped     = r_clamped;
   assign bus.edit_active = r_edit_active;
   assign bus.edit_digit  = r_edit_digit;
   assign bus.stg_tens    = r_stg_tens;
   assign bus.stg_ones    = r_stg_ones;
   assign bus.stg_frac    = r_stg_frac;
   assign bus.stg_sign    = r_stg_sign;

endmodule
